dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares the single-port, word-wide data memory between two requesters: port 0 = core load/store
//   unit, port 1 = debug/program loader.
// - Adds RISC-V sub-word access: byte/halfword loads are extracted and extended; byte/halfword
//   stores use read-modify-write, since the memory only writes full words.
// - Sits between the requesters and the data memory; it owns the memory's address/write-enable/data.
// PARAMETERS
// - MEM_WORDS  256  words in data memory; byte addresses >= 4*MEM_WORDS are out of range
// PORTS
// - clk               in   1   clock, all state on rising edge
// - rst               in   1   asynchronous reset, active-high
// - req_valid[p]      in   1   request present on port p (p = 0, 1)
// - req_ready[p]      out  1   request accepted this cycle (valid & ready = handshake)
// - req_addr[p]       in   32  byte address
// - req_we[p]         in   1   1 = store, 0 = load
// - req_funct3[p]     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (loads); stores: 000/001/010
// - req_wdata[p]      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - rsp_valid[p]      out  1   one-cycle completion pulse for port p
// - rsp_rdata         out  32  load result, valid with rsp_valid; 0 for stores and errors
// - rsp_error         out  1   misaligned, out-of-range or illegal funct3, valid with rsp_valid
// - mem_byte_address  out  32  to data memory
// - mem_write_enable  out  1   to data memory
// - mem_write_data    out  32  to data memory
// - mem_read_data     in   32  from data memory, combinational read of mem_byte_address
// BEHAVIOUR
// - FSM states: IDLE, ACCESS, MERGE_WR, RESP. Reset -> IDLE.
// - Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, mem_write_enable 0,
//   mem_byte_address 0, mem_write_data 0, last_grant = 1 (port 0 wins the first tie).
// - IDLE: req_ready is high only in IDLE and only for the granted port. Grant rules:
//   - only one port valid: that port;
//   - both valid: the port != last_grant (round-robin).
// - Handshake: the request is latched into internal registers and last_grant is updated; go to ACCESS.
// - Requesters hold their request fields stable while valid & !ready. At most one handshake per cycle.
// - Error check at acceptance:
//   - H with addr[0] != 0, W with addr[1:0] != 0, addr >= 4*MEM_WORDS, or an undefined funct3;
//   - any of these goes directly to RESP with rsp_error = 1;
//   - the memory is never written on an error.
// - ACCESS: drive mem_byte_address = latched addr.
//   - Load: capture the mem_read_data lane selected by addr[1:0];
//     - B/H are sign-extended; BU/HU are zero-extended;
//     - go to RESP.
//   - Store W: mem_write_enable = 1 and mem_write_data = wdata this cycle; go to RESP.
//   - Store B/H: capture mem_read_data, merge wdata into the addressed lane(s); go to MERGE_WR.
// - MERGE_WR: mem_write_enable = 1 with the merged word at the same address; go to RESP.
// - RESP: rsp_valid[owner] = 1 for exactly one cycle with rsp_rdata and rsp_error; next state IDLE.
//   There is no response backpressure.
// - Latency from the handshake cycle T: load and word store respond at T+2; sub-word store responds
//   at T+3; an error responds at T+1.
// - Outside ACCESS and MERGE_WR, mem_write_enable = 0; mem_write_enable is decoded from the state
//   register, so asserting rst drops it immediately.
// - Reset mid-operation: the in-flight request is dropped, there is no rsp_valid, and no partial write
//   completes after reset. A write already clocked in before reset remains in the memory.
// - Port stalls: a port is held off (ready = 0) while the other port's transaction is in flight; with
//   both ports continuously valid, grants alternate 0,1,0,1.
// TESTING
// - Reset, then port0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid[0] at T+2 with rdata
//   0xDEADBEEF, rsp_error 0.
// - With word 0x10 = 0xDEADBEEF: SB 0x12 data 0x55 (rsp at T+3), then LW 0x10 -> 0xDE55BEEF;
//   then LB 0x13 -> 0xFFFFFFDE, LBU 0x13 -> 0x000000DE, LHU 0x12 -> 0x0000DE55.
// - LH 0x11, SW 0x12, LW 0x400 (MEM_WORDS = 256) -> each gives rsp_error 1 at T+1,
//   mem_write_enable never high, memory unchanged.
// - Both ports valid continuously for 4 requests each -> grant order 0,1,0,1,... and each port sees
//   exactly 4 rsp_valid pulses, none on the wrong port.
// - Assert rst during MERGE_WR of an SH -> mem_write_enable low in the same cycle; after release:
//   IDLE, no rsp_valid, and a following LW returns the pre-store word.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port, word-wide data memory between two requesters
// (port 0 = core load/store unit, port 1 = debug/program loader) and adds
// RISC-V sub-word access on top of it. Byte/halfword loads are extracted from
// the addressed lane and sign- or zero-extended. Byte/halfword stores are done
// as read-modify-write because the memory only writes whole words.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   req_valid/ready   per-port request handshake; ready only in IDLE, only for
//                     the granted port
//   req_addr          per-port byte address
//   req_we            per-port 1 = store, 0 = load
//   req_funct3        per-port RISC-V funct3 (B/H/W/BU/HU)
//   req_wdata         per-port right-aligned store data
//   rsp_valid         per-port one-cycle completion pulse
//   rsp_rdata         load result (0 for stores and errors)
//   rsp_error         misaligned, out-of-range or illegal funct3
//   mem_*             address / write enable / write data to the memory and
//                     its combinational read data back
module dmem_arbiter #(
  parameter int MEM_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0]       req_we,
  input  logic [1:0][2:0]  req_funct3,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_error,
  output logic [31:0]      mem_byte_address,
  output logic             mem_write_enable,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] MERGE_WR = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        grant;
  logic        handshake;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [2:0]  sel_f3;
  logic        req_err;
  logic        f3_legal;
  logic        misaligned;
  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  // Round-robin arbitration: on a tie the port that did not win last time
  // gets the memory; otherwise whichever port is asking.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) grant = ~last_grant_q;
    else                    grant = req_valid[1];
  end

  // Ready is held low during reset so nothing can be accepted while the
  // state register is being cleared.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && !rst) begin
      if (grant) req_ready[1] = req_valid[1];
      else       req_ready[0] = req_valid[0];
    end
  end

  assign handshake = |req_ready;
  assign sel_addr  = req_addr[grant];
  assign sel_we    = req_we[grant];
  assign sel_f3    = req_funct3[grant];

  // Acceptance-time checks; a failing request never touches the memory.
  always_comb begin
    f3_legal = 1'b0;
    case (sel_f3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~sel_we;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((sel_f3[1:0] == 2'b01) && sel_addr[0]) ||
                 ((sel_f3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
    req_err = !f3_legal || misaligned || (sel_addr >= ADDR_LIMIT);
  end

  // Lane extraction for loads and lane merge for sub-word stores, both
  // relative to the latched byte offset.
  assign shamt     = {addr_q[1:0], 3'b000};
  assign lane      = mem_read_data >> shamt;
  assign lane_mask = ((f3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
  assign merged    = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    load_val = 32'h0;
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_val = mem_read_data;
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = 32'h0;
    endcase
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (handshake) state_d = req_err ? RESP : ACCESS;
      ACCESS:   state_d = (we_q && f3_q != 3'b010) ? MERGE_WR : RESP;
      MERGE_WR: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      rdata_q      <= 32'h0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            last_grant_q <= grant;
            owner_q      <= grant;
            addr_q       <= sel_addr;
            we_q         <= sel_we;
            f3_q         <= sel_f3;
            wdata_q      <= req_wdata[grant];
            error_q      <= req_err;
            rdata_q      <= 32'h0;
          end
        end
        ACCESS: begin
          if (!we_q)                  rdata_q  <= load_val;
          else if (f3_q != 3'b010)    merged_q <= merged;
        end
        default: ;
      endcase
    end
  end

  // Memory controls decode straight from the state register so an asserted
  // reset removes a pending write in the same cycle.
  always_comb begin
    mem_byte_address = addr_q;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;
    if (state_q == ACCESS && we_q && f3_q == 3'b010) begin
      mem_write_enable = 1'b1;
      mem_write_data   = wdata_q;
    end else if (state_q == MERGE_WR) begin
      mem_write_enable = 1'b1;
      mem_write_data   = merged_q;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    rsp_rdata = 32'h0;
    rsp_error = 1'b0;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
      rsp_rdata          = rdata_q;
      rsp_error          = error_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A behavioural word memory sits on the
// memory port. Each accepted request pushes its hand-computed response into a
// per-port queue; an independent monitor pops and compares whenever rsp_valid
// pulses, including response latency measured from the handshake cycle.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Clock generation
  always #5 clk = ~clk;

  logic        vld [2];
  logic        wen [2];
  logic [2:0]  f3  [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_addr;
  logic [1:0]       req_we;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_error;
  logic [31:0]      mem_byte_address;
  logic             mem_write_enable;
  logic [31:0]      mem_write_data;
  logic [31:0]      mem_read_data;

  assign req_valid  = {vld[1], vld[0]};
  assign req_we     = {wen[1], wen[0]};
  assign req_funct3 = {f3[1], f3[0]};
  assign req_addr   = {adr[1], adr[0]};
  assign req_wdata  = {wd[1], wd[0]};

  dmem_arbiter #(.MEM_WORDS(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .mem_byte_address (mem_byte_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Behavioural word memory with combinational read and a write counter
  logic [31:0] mem [256];
  int wr_count = 0;
  int cyc = 0;

  assign mem_read_data = mem[mem_byte_address[9:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_byte_address[9:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  // Free-running edge counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one request from port p starting at a negedge, wait (bounded) for
  // the handshake, then push the expected response unless told not to.
  task automatic applyStimulus(input int p, input logic st, input logic [2:0] fn,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rd, input logic exp_err,
                               input int lat, input bit push);
    int   waited = 0;
    bit   done = 0;
    exp_t e;
    vld[p] = 1'b1; wen[p] = st; f3[p] = fn; adr[p] = a; wd[p] = d;
    while (!done) begin
      #1;
      if (req_ready[p]) begin
        e.rdata = exp_rd; e.err = exp_err; e.hs = cyc; e.lat = lat;
        if (push) begin
          if (p == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        grant_log.push_back(p);
        done = 1;
        @(posedge clk);
        #1;
        vld[p] = 1'b0;
        @(negedge clk);
      end else if (waited > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL handshake_timeout port=%0d actual=no_ready required=ready", p);
        vld[p] = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
  endtask

  // Wait (bounded) for every expected response to have been seen
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d/%0d pending required=0/0", q0.size(), q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Response monitor: pops the port's queue on every rsp_valid pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] === 1'b1) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_rsp port=%0d actual=pulse required=none", p);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("rdata_p%0d", p), rsp_rdata, e.rdata);
            checkOutput($sformatf("error_p%0d", p), {31'h0, rsp_error}, {31'h0, e.err});
            checkOutput($sformatf("latency_p%0d", p), 32'(cyc - e.hs), 32'(e.lat));
          end
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    int wr0;
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; wen[p] = 1'b0; f3[p] = 3'b000; adr[p] = 32'h0; wd[p] = 32'h0;
    end
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {30'h0, req_ready}, 32'h0);
    checkOutput("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
    checkOutput("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
    checkOutput("rst_mem_addr", mem_byte_address, 32'h0);
    checkOutput("rst_mem_wdata", mem_write_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then load back
    applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1);
    drain();

    // Byte store by read-modify-write, then sub-word loads
    applyStimulus(0, 1'b1, 3'b000, 32'h12, 32'h0000_0055, 32'h0, 1'b0, 3, 1);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 2, 1);
    applyStimulus(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1);
    applyStimulus(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1);
    applyStimulus(0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DE55, 1'b0, 2, 1);
    applyStimulus(0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDE55, 1'b0, 2, 1);
    applyStimulus(0, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 1);
    drain();

    // Error cases: misaligned, out of range, illegal funct3
    wr0 = wr_count;
    applyStimulus(0, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1, 1);
    applyStimulus(0, 1'b1, 3'b010, 32'h12, 32'h1111_2222, 32'h0, 1'b1, 1, 1);
    applyStimulus(0, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 1);
    applyStimulus(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1);
    applyStimulus(0, 1'b1, 3'b100, 32'h10, 32'h0000_00AA, 32'h0, 1'b1, 1, 1);
    drain();
    checkOutput("err_no_writes", 32'(wr_count - wr0), 32'h0);
    checkOutput("err_mem_unchanged", mem[4], 32'hDE55BEEF);

    // Reset during MERGE_WR of a halfword store
    wr0 = wr_count;
    applyStimulus(0, 1'b1, 3'b001, 32'h20, 32'h0000_1234, 32'h0, 1'b0, 3, 0);
    @(posedge clk);
    #1;
    checkOutput("merge_we_high", {31'h0, mem_write_enable}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("reset_drops_we", {31'h0, mem_write_enable}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_no_rsp", {30'h0, rsp_valid}, 32'h0);
    checkOutput("reset_no_write", 32'(wr_count - wr0), 32'h0);
    applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hA500_0008, 1'b0, 2, 1);
    drain();

    // Both ports continuously valid: grants must alternate starting with 0
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus(0, 1'b0, 3'b010, 32'h40 + 32'(4 * i), 32'h0, 32'hA500_0010 + 32'(i), 1'b0, 2, 1);
      end
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus(1, 1'b0, 3'b010, 32'h80 + 32'(4 * i), 32'h0, 32'hA500_0020 + 32'(i), 1'b0, 2, 1);
      end
    join
    drain();
    checkOutput("grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      checkOutput($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
